mmio_hub: RTL and testbench

Parametrised memory-mapped I/O hub for the single-cycle MIPS core. It replaces the fixed one-bank switch/LED path with NUM_CH independent channels. Each channel has synchronised and debounced switch inputs, a writable LED register, and rising-edge capture with a maskable interrupt. It sits between the control unit's IORead/IOWrite strobes, the ALU address and the board pins.

---
 rtl/mmio_hub_if.sv | 20 ++
 rtl/mmio_hub.sv | 135 +++++++++++++
 tb/tb_mmio_hub.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_hub_if.sv
// Core-side MMIO bus for mmio_hub: address, read/write strobes, write data, and registered
// read data with its valid pulse.
interface mmio_hub_if;
  logic [31:0] addr;
  logic        io_read;
  logic        io_write;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rd_valid;

  modport master (
    output addr, io_read, io_write, wdata,
    input  rdata, rd_valid
  );

  modport slave (
    input  addr, io_read, io_write, wdata,
    output rdata, rd_valid
  );
endinterface

// File: rtl/mmio_hub.sv
// Multi-channel switch/LED MMIO hub with synchronised inputs, rising-edge capture and irq.
// Define MMIO_DEBOUNCE_EN to insert the per-channel switch debouncer.
module mmio_hub #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned SW_W            = 16,
  parameter int unsigned LED_W           = 16,
  parameter logic [31:0] IO_BASE         = 32'hFFFF_FC00,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic                    clock,
  input  logic                    rst,
  mmio_hub_if.slave               bus,
  input  logic [NUM_CH*SW_W-1:0]  sw_in,
  output logic [NUM_CH*LED_W-1:0] led_out,
  output logic                    irq
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef logic [NUM_CH-1:0][SW_W-1:0] sw_arr_t;

  sw_arr_t sync1_q, sync2_q;
  sw_arr_t stab_q, stab_d, stab_prev_q;
  sw_arr_t pend_q, pend_d;
  sw_arr_t ien_q, ien_d;
  logic [NUM_CH-1:0][LED_W-1:0] led_q, led_d;

  logic [31:0]     offset;
  logic            in_range;
  logic [CH_W-1:0] ch_sel;
  logic [1:0]      reg_sel;
  logic [NUM_CH-1:0] wr_hit;
  logic [31:0]     rd_mux;
  logic [31:0]     rdata_q;
  logic            rd_valid_q;

  // Base-relative offset; addresses below IO_BASE wrap high and fall out of range.
  assign offset   = bus.addr - IO_BASE;
  assign in_range = offset < 32'(16 * NUM_CH);
  assign ch_sel   = offset[4 +: CH_W];
  assign reg_sel  = offset[3:2];

  always_comb begin
    wr_hit = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_hit[c] = bus.io_write && in_range && (ch_sel == CH_W'(c));
    end
  end

  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      unique case (reg_sel)
        2'd0:    rd_mux = 32'(stab_q[ch_sel]);
        2'd1:    rd_mux = 32'(led_q[ch_sel]);
        2'd2:    rd_mux = 32'(pend_q[ch_sel]);
        default: rd_mux = 32'(ien_q[ch_sel]);
      endcase
    end
  end

  // A new rising edge is OR-ed in after the W1C mask so a same-cycle set survives the clear.
  always_comb begin
    led_d  = led_q;
    ien_d  = ien_q;
    pend_d = pend_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_hit[c] && reg_sel == 2'd1) led_d[c] = bus.wdata[LED_W-1:0];
      if (wr_hit[c] && reg_sel == 2'd3) ien_d[c] = bus.wdata[SW_W-1:0];
      if (wr_hit[c] && reg_sel == 2'd2) pend_d[c] = pend_q[c] & ~bus.wdata[SW_W-1:0];
      pend_d[c] = pend_d[c] | (stab_q[c] & ~stab_prev_q[c]);
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  logic [NUM_CH-1:0][15:0] cnt_q, cnt_d;

  // One counter per channel; any cycle where sync matches stab restarts it.
  always_comb begin
    stab_d = stab_q;
    cnt_d  = cnt_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sync2_q[c] == stab_q[c]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] == DEBOUNCE_CYCLES - 16'd1) begin
        stab_d[c] = sync2_q[c];
        cnt_d[c]  = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign stab_d = sync2_q;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stab_q      <= '0;
      stab_prev_q <= '0;
      pend_q      <= '0;
      ien_q       <= '0;
      led_q       <= '0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      sync1_q     <= sw_in;
      sync2_q     <= sync1_q;
      stab_q      <= stab_d;
      stab_prev_q <= stab_q;
      pend_q      <= pend_d;
      ien_q       <= ien_d;
      led_q       <= led_d;
      rd_valid_q  <= bus.io_read;
      if (bus.io_read) rdata_q <= rd_mux;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;
  assign led_out      = led_q;
  assign irq          = |(pend_q & ien_q);

  logic unused_bits;
  assign unused_bits = ^{bus.wdata, offset, DEBOUNCE_CYCLES};
endmodule

// File: tb/tb_mmio_hub.sv
// Self-checking bench for mmio_hub: directed steps followed by randomized bus and switch
// traffic, all compared every cycle against a behavioural model of the register map.
module tb_mmio_hub;
  localparam int unsigned NC   = 2;
  localparam int unsigned SW   = 16;
  localparam int unsigned LW   = 16;
  localparam logic [15:0] DB   = 16'd4;
  localparam logic [31:0] BASE = 32'hFFFF_FC00;
`ifdef MMIO_DEBOUNCE_EN
  localparam int LAT = 2 + int'(DB);
`else
  localparam int LAT = 3;
`endif

  logic              clock = 1'b0;
  logic              rst   = 1'b1;
  logic [NC*SW-1:0]  sw_in = '0;
  logic [NC*LW-1:0]  led_out;
  logic              irq;

  mmio_hub_if bus();

  mmio_hub #(
    .NUM_CH(NC),
    .SW_W(SW),
    .LED_W(LW),
    .IO_BASE(BASE),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus),
    .sw_in(sw_in),
    .led_out(led_out),
    .irq(irq)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NC*SW-1:0] m_pin1, m_pin2;
  int               m_run  [NC];
  logic [SW-1:0]    m_stab [NC];
  logic [SW-1:0]    m_stab_old [NC];
  logic [SW-1:0]    m_pend [NC];
  logic [SW-1:0]    m_ien  [NC];
  logic [LW-1:0]    m_led  [NC];
  logic [31:0]      m_rdata;
  logic             m_rdv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pin1  = '0;
    m_pin2  = '0;
    m_rdata = '0;
    m_rdv   = 1'b0;
    for (int c = 0; c < NC; c++) begin
      m_run[c]      = 0;
      m_stab[c]     = '0;
      m_stab_old[c] = '0;
      m_pend[c]     = '0;
      m_ien[c]      = '0;
      m_led[c]      = '0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] off;
    int          c;
    off = a - BASE;
    if (off >= 32'(16 * NC)) return 32'h0;
    c = int'(off / 16);
    case ((off % 16) / 4)
      0:       return {16'h0, m_stab[c]};
      1:       return {16'h0, m_led[c]};
      2:       return {16'h0, m_pend[c]};
      default: return {16'h0, m_ien[c]};
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [31:0] off;
    int          wc;
    int          wr;
    logic        wok;
    logic [SW-1:0] rise;
    logic [SW-1:0] clr;
    logic [SW-1:0] synced;
    if (bus.io_read) m_rdata = model_read(bus.addr);
    m_rdv = bus.io_read;
    off = bus.addr - BASE;
    wok = bus.io_write && (off < 32'(16 * NC));
    wc  = int'(off / 16);
    wr  = int'((off % 16) / 4);
    for (int c = 0; c < NC; c++) begin
      rise = m_stab[c] & ~m_stab_old[c];
      clr  = (wok && wc == c && wr == 2) ? bus.wdata[SW-1:0] : '0;
      m_pend[c] = (m_pend[c] & ~clr) | rise;
      if (wok && wc == c && wr == 1) m_led[c] = bus.wdata[LW-1:0];
      if (wok && wc == c && wr == 3) m_ien[c] = bus.wdata[SW-1:0];
      m_stab_old[c] = m_stab[c];
      synced = m_pin2[c*SW +: SW];
`ifdef MMIO_DEBOUNCE_EN
      if (synced == m_stab[c]) begin
        m_run[c] = 0;
      end else begin
        m_run[c]++;
        if (m_run[c] >= int'(DB)) begin
          m_stab[c] = synced;
          m_run[c]  = 0;
        end
      end
`else
      m_stab[c] = synced;
`endif
    end
    m_pin2 = m_pin1;
    m_pin1 = sw_in;
  endtask

  task automatic step();
    logic [31:0] exp_led;
    logic        exp_irq;
    @(posedge clock);
    if (rst) model_reset();
    else model_edge();
    #1;
    exp_led = '0;
    exp_irq = 1'b0;
    for (int c = 0; c < NC; c++) begin
      exp_led[c*LW +: LW] = m_led[c];
      exp_irq = exp_irq | (|(m_pend[c] & m_ien[c]));
    end
    check("m_rd_valid", {31'h0, bus.rd_valid}, {31'h0, m_rdv});
    check("m_rdata", bus.rdata, m_rdata);
    check("m_led_out", led_out, exp_led);
    check("m_irq", {31'h0, irq}, {31'h0, exp_irq});
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.io_write = 1'b1;
    bus.addr     = a;
    bus.wdata    = d;
    step();
    bus.io_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    bus.io_read = 1'b1;
    bus.addr    = a;
    step();
    bus.io_read = 1'b0;
  endtask

  initial begin
    bus.addr     = '0;
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;
    bus.wdata    = '0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    check("rst_led", led_out, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);

    // Every offset of both channels, back to back
    bus.io_read = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.addr = BASE + 32'(4 * i);
      step();
      check("rd_all_valid", {31'h0, bus.rd_valid}, 32'h1);
      check("rd_all_data", bus.rdata, 32'h0);
    end
    bus.io_read = 1'b0;
    step();
    check("rd_idle", {31'h0, bus.rd_valid}, 32'h0);

    bus_write(BASE + 32'h4, 32'h0000_A5C3);
    bus_write(BASE + 32'h14, 32'h0000_1234);
    check("led_pair", led_out, 32'h1234_A5C3);
    bus_read(BASE + 32'h4);
    check("rb_led0", bus.rdata, 32'h0000_A5C3);
    bus_read(BASE + 32'h14);
    check("rb_led1", bus.rdata, 32'h0000_1234);
    bus_write(BASE + 32'h0, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h0);
    check("sw_ro", bus.rdata, 32'h0);

    // Three-cycle glitch: filtered only when the debouncer is present
    sw_in[0] = 1'b1;
    repeat (3) step();
    sw_in[0] = 1'b0;
    repeat (LAT + 4) step();
    bus_read(BASE);
    check("sw_after_glitch", bus.rdata, 32'h0);
    bus_read(BASE + 32'h8);
`ifdef MMIO_DEBOUNCE_EN
    check("pend_glitch", bus.rdata, 32'h0);
`else
    check("pend_glitch", bus.rdata, 32'h1);
`endif
    bus_write(BASE + 32'h8, 32'h0000_FFFF);
    bus_write(BASE + 32'hC, 32'h1);
    check("irq_clear0", {31'h0, irq}, 32'h0);

    // Held rise: stab after LAT edges, PEND/irq one edge later
    sw_in[0] = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      check("irq_pre", {31'h0, irq}, 32'h0);
    end
    step();
    check("irq_rise", {31'h0, irq}, 32'h1);
    bus_read(BASE + 32'h8);
    check("pend_set", bus.rdata, 32'h1);
    bus_read(BASE);
    check("sw_stab", bus.rdata, 32'h1);
    bus_write(BASE + 32'h8, 32'h1);
    check("irq_w1c", {31'h0, irq}, 32'h0);
    bus_read(BASE + 32'h8);
    check("pend_w1c", bus.rdata, 32'h0);
    sw_in[0] = 1'b0;
    repeat (LAT + 3) step();
    check("no_fall_capture", {31'h0, irq}, 32'h0);

    // Clear lands on the same edge as a new set
    sw_in[0] = 1'b1;
    repeat (LAT) step();
    bus_write(BASE + 32'h8, 32'h1);
    check("conflict_irq", {31'h0, irq}, 32'h1);
    bus_read(BASE + 32'h8);
    check("conflict_pend", bus.rdata, 32'h1);

    bus_read(BASE + 32'h4);
    check("rb_led0_again", bus.rdata, 32'h0000_A5C3);
    bus_read(BASE + 32'h40);
    check("oor_valid", {31'h0, bus.rd_valid}, 32'h1);
    check("oor_data", bus.rdata, 32'h0);
    bus_read(BASE - 32'h4);
    check("below_base", bus.rdata, 32'h0);

    // Reset between a read strobe and its edge
    bus.io_read = 1'b1;
    bus.addr    = BASE + 32'h4;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_led", led_out, 32'h0);
    check("async_irq", {31'h0, irq}, 32'h0);
    step();
    check("rst_read_valid", {31'h0, bus.rd_valid}, 32'h0);
    bus.io_read = 1'b0;
    rst = 1'b0;
    step();
    check("post_rst_valid", {31'h0, bus.rd_valid}, 32'h0);

    // Randomized traffic against the model
    repeat (800) begin
      bus.io_read  = 1'($urandom_range(0, 1));
      bus.io_write = ($urandom_range(0, 2) == 0);
      bus.wdata    = $urandom;
      if ($urandom_range(0, 5) == 0) bus.addr = $urandom;
      else bus.addr = BASE + $urandom_range(0, 16 * NC + 15);
      if ($urandom_range(0, 5) == 0) sw_in[$urandom_range(0, NC * SW - 1)] ^= 1'b1;
      step();
    end
    bus.io_read  = 1'b0;
    bus.io_write = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
